// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake and per-frame bit order.
// Emits one bit per enabled cycle, pulses done on the last bit and supports a synchronous abort.
module piso_serializer #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             msb_first,
   input  logic             shift_en,
   input  logic             abort,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shreg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_dir;
   logic [CW-1:0]    r_cnt;
   logic             r_ser_out;
   logic             r_ser_valid;
   logic             r_done;

   logic             w_accept;
   logic             w_abort;
   logic             w_step;
   logic             w_last;

   // Bit presented at the emitting end of the word for the selected order.
   function automatic logic emit_bit(input logic [WIDTH-1:0] word, input logic dir);
      emit_bit = dir ? word[WIDTH-1] : word[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word, input logic dir);
      shift_word = dir ? (word << 1) : (word >> 1);
   endfunction

   assign w_accept = (r_state == S_IDLE) && load_valid;
   assign w_abort  = (r_state == S_SHIFT) && abort;
   assign w_step   = (r_state == S_SHIFT) && !abort && shift_en;
   assign w_last   = w_step && (r_cnt == CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (load_valid) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort || (shift_en && (r_cnt == CW'(1)))) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load_ready = (r_state == S_IDLE);
      busy       = (r_state == S_SHIFT);
   end

   // Datapath: load capture, bit emission, hold on disabled cycles, abort flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg     <= '0;
         r_dir       <= 1'b0;
         r_cnt       <= '0;
         r_ser_out   <= IDLE_LEVEL;
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
      end else if (w_abort) begin
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_ser_out   <= IDLE_LEVEL;
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
      end else if (w_step) begin
         r_ser_out   <= emit_bit(r_shreg, r_dir);
         r_ser_valid <= 1'b1;
         r_shreg     <= shift_word(r_shreg, r_dir);
         r_cnt       <= r_cnt - CW'(1);
         r_done      <= w_last;
      end else if (r_state == S_SHIFT) begin
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_ser_out   <= IDLE_LEVEL;
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
         if (w_accept) begin
            r_shreg <= load_data;
            r_dir   <= msb_first;
            r_cnt   <= CW'(WIDTH);
         end
      end
   end

   assign ser_out   = r_ser_out;
   assign ser_valid = r_ser_valid;
   assign done      = r_done;
   assign shreg     = r_shreg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: expected bits are queued at load accept and compared as the DUT emits them.
module tb_piso_serializer;

   localparam int   W    = 8;
   localparam logic IDLE = 1'b0;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_data;
   logic         msb_first;
   logic         shift_en;
   logic         abort;
   logic         ser_out;
   logic         ser_valid;
   logic         busy;
   logic         done;
   logic [W-1:0] shreg;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   nvalid = 0;
   int   ndone  = 0;

   piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .msb_first(msb_first), .shift_en(shift_en), .abort(abort),
      .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done), .shreg(shreg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every emitted bit must match the head of the queue.
   always @(negedge clk) begin
      if (ser_valid) begin
         nvalid++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bit: ser_out=%0b with no bit expected", ser_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (ser_out !== e.b || done !== e.last) begin
               bad++;
               $display("FAIL bit: ser_out=%0b done=%0b, required ser_out=%0b done=%0b",
                        ser_out, done, e.b, e.last);
            end
            if (e.last) begin
               ndone++;
               total++;
               if (load_ready !== 1'b1 || busy !== 1'b0) begin
                  bad++;
                  $display("FAIL last_bit_state: load_ready=%0b busy=%0b, required 1 0",
                           load_ready, busy);
               end
            end
         end
      end else if (done) begin
         total++;
         bad++;
         $display("FAIL done_without_valid: done=1 ser_valid=0, required done=0");
      end
   end

   task automatic do_load(input logic [W-1:0] data, input logic msb);
      int n = 0;
      while (!load_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL load_wait: load_ready=%0b after %0d cycles, required 1", load_ready, n);
      end
      load_valid = 1'b1;
      load_data  = data;
      msb_first  = msb;
      @(posedge clk);
      for (int i = 0; i < W; i++) begin
         exp_t e;
         e.b    = msb ? data[W-1-i] : data[i];
         e.last = (i == W - 1);
         exp_q.push_back(e);
      end
      #1;
      load_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= max_cycles) begin
         bad++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle", busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b0; load_data = '0; msb_first = 1'b0;
      shift_en = 1'b1; abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (ser_out !== IDLE || ser_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || shreg !== '0) begin
         bad++;
         $display("FAIL reset_state: ser_out=%0b ser_valid=%0b busy=%0b done=%0b shreg=%h, required 0 0 0 0 00",
                  ser_out, ser_valid, busy, done, shreg);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      total++;
      if (load_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: load_ready=%0b, required 1", load_ready);
      end
   endtask

   task automatic test_lsb();
      int d0 = ndone;
      do_load(8'h1E, 1'b0);
      total++;
      if (busy !== 1'b1 || ser_valid !== 1'b0 || load_ready !== 1'b0) begin
         bad++;
         $display("FAIL lsb_accept: busy=%0b ser_valid=%0b load_ready=%0b, required 1 0 0",
                  busy, ser_valid, load_ready);
      end
      @(posedge clk); #1;
      total++;
      if (ser_valid !== 1'b1) begin
         bad++;
         $display("FAIL lsb_latency: ser_valid=%0b one cycle after accept, required 1", ser_valid);
      end
      wait_idle(40);
      total++;
      if (ser_out !== IDLE || ndone != d0 + 1) begin
         bad++;
         $display("FAIL lsb_end: ser_out=%0b frames_done=%0d, required %0b %0d",
                  ser_out, ndone - d0, IDLE, 1);
      end
   endtask

   task automatic test_msb();
      do_load(8'h1E, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (shreg !== 8'hE0) begin
         bad++;
         $display("FAIL msb_shreg: shreg=%h after 4 bits, required e0", shreg);
      end
      msb_first = 1'b0;
      wait_idle(40);
   endtask

   task automatic test_gated();
      int v0 = nvalid;
      do_load(8'hFF, 1'b0);
      for (int i = 0; i < 16; i++) begin
         shift_en = (i % 2 == 0);
         @(posedge clk); #1;
         if (i % 2 == 1 && i < 15) begin
            total++;
            if (busy !== 1'b1 || ser_valid !== 1'b0 || ser_out !== 1'b1) begin
               bad++;
               $display("FAIL gated_hold[%0d]: busy=%0b ser_valid=%0b ser_out=%0b, required 1 0 1",
                        i, busy, ser_valid, ser_out);
            end
         end
      end
      shift_en = 1'b1;
      wait_idle(10);
      total++;
      if (nvalid - v0 != W) begin
         bad++;
         $display("FAIL gated_count: pulses=%0d, required %0d", nvalid - v0, W);
      end
   endtask

   task automatic test_busy_ignore();
      do_load(8'hAA, 1'b0);
      load_valid = 1'b1;
      load_data  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready[%0d]: load_ready=%0b, required 0", i, load_ready);
         end
      end
      load_valid = 1'b0;
      wait_idle(40);
      do_load(8'h55, 1'b0);
      wait_idle(40);
   endtask

   task automatic test_abort();
      int d0 = ndone;
      do_load(8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      total++;
      if (busy !== 1'b0 || shreg !== '0 || ser_out !== IDLE || ser_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: busy=%0b shreg=%h ser_out=%0b ser_valid=%0b done=%0b, required 0 00 0 0 0",
                  busy, shreg, ser_out, ser_valid, done);
      end
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (ndone != d0) begin
         bad++;
         $display("FAIL abort_done: frames_done=%0d, required 0", ndone - d0);
      end
      abort = 1'b1;
      do_load(8'hC3, 1'b1);
      abort = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_idle_load: busy=%0b, required 1", busy);
      end
      wait_idle(40);
      total++;
      if (ndone != d0 + 1) begin
         bad++;
         $display("FAIL abort_next_frame: frames_done=%0d, required 1", ndone - d0);
      end
   endtask

   task automatic test_async_reset();
      int v0;
      do_load(8'hB7, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      exp_q.delete();
      total++;
      if (busy !== 1'b0 || shreg !== '0 || ser_out !== IDLE || ser_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: busy=%0b shreg=%h ser_out=%0b ser_valid=%0b done=%0b, required 0 00 0 0 0",
                  busy, shreg, ser_out, ser_valid, done);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      v0 = nvalid;
      total++;
      if (load_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_reset_ready: load_ready=%0b, required 1", load_ready);
      end
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (nvalid != v0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_residual: pulses=%0d busy=%0b, required 0 0", nvalid - v0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = ndone;
      for (int f = 0; f < 4; f++) begin
         logic [W-1:0] d;
         d = W'($urandom_range(0, 255));
         do_load(d, logic'(f % 2));
      end
      wait_idle(40);
      total++;
      if (ndone != d0 + 4) begin
         bad++;
         $display("FAIL back_to_back: frames_done=%0d, required 4", ndone - d0);
      end
   endtask

   initial begin
      test_reset();
      test_lsb();
      test_msb();
      test_gated();
      test_busy_ignore();
      test_abort();
      test_async_reset();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_bits: pending=%0d, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift register: the next generation of the 4-bit PISO. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, LSB-first or MSB-first as selected per frame. It flags each emitted bit, pulses done on the last bit, and supports a synchronous abort. It sits between parallel datapath logic and any serial link or bit-banged peripheral in the design.

Parameters:
WIDTH, 8, word length in bits; legal range WIDTH >= 2.
IDLE_LEVEL, 1'b0, value driven on ser_out while no frame is in flight.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a word (high only in IDLE)
load_data  input  WIDTH  parallel word to serialise
msb_first  input  1  bit order; sampled only on load accept (1 = MSB first)
shift_en  input  1  bit-rate enable; one bit is emitted per enabled SHIFT cycle
abort  input  1  synchronous frame abort
ser_out  output  1  serial data (registered)
ser_valid  output  1  ser_out carries a new bit this cycle (one cycle per bit)
busy  output  1  frame in flight (state == SHIFT)
done  output  1  one-cycle pulse coincident with the last bit's ser_valid
shreg  output  WIDTH  live shift-register contents (debug/parallel view)

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, shreg=0, bit counter=0, ser_out=IDLE_LEVEL, ser_valid=0, done=0, busy=0, load_ready=1 once reset deasserts. No partial frame resumes.
- FSM has two states, IDLE and SHIFT. load_ready = (state==IDLE), busy = (state==SHIFT), both combinational from state.
- IDLE: at a posedge with load_valid && load_ready, the block captures shreg<=load_data, dir<=msb_first, cnt<=WIDTH, and moves to SHIFT. With load_valid low it stays in IDLE; ser_out=IDLE_LEVEL, ser_valid=0.
- SHIFT, at a posedge with shift_en=1: ser_out<=shreg[0] (LSB-first) or shreg[WIDTH-1] (MSB-first); ser_valid<=1; shreg shifts toward the emitting end with zero fill; cnt<=cnt-1.
- SHIFT, at a posedge with shift_en=0: ser_valid<=0; ser_out holds its last value; shreg and cnt hold.
- Last bit: on the enabled posedge where cnt==1, the block also sets done<=1 and state<=IDLE. done and ser_valid are high in the same cycle, and busy is already low in that cycle. On the following posedge, ser_out<=IDLE_LEVEL unless a new bit is emitted.
- Latency: load accepted at edge k with shift_en held high gives bit0 valid after edge k+1 and the last bit plus done after edge k+WIDTH. A new load can be accepted at edge k+WIDTH+1 at the earliest, which gives 1 idle cycle between frames.
- load_valid while busy is ignored; the word is not queued. The upstream side must hold it until load_ready is high.
- abort (SHIFT only): at the posedge it forces state=IDLE, shreg=0, cnt=0, ser_valid=0, done=0, ser_out=IDLE_LEVEL. abort takes priority over shift_en. abort in IDLE has no effect; a load in the same cycle is still accepted.
- Counter width is $clog2(WIDTH+1). Exactly WIDTH ser_valid pulses occur per non-aborted frame.
- msb_first changes mid-frame have no effect on the frame in flight.

Test Plan:
- WIDTH=8, load 0x1E, msb_first=0, shift_en=1 -> ser_out on the valid cycles is 0,1,1,1,1,0,0,0; done coincides with the 8th ser_valid; load_ready is high in the same cycle; ser_out=IDLE_LEVEL after.
- Load 0x1E with msb_first=1 -> ser_out 0,0,0,1,1,1,1,0; shreg after 4 bits = 0xE0.
- Load 0xFF with shift_en toggling 1,0,1,0 -> 8 ser_valid pulses spread over 16 cycles; ser_out holds 1 during disabled cycles; busy is high throughout.
- Load 0xAA, assert load_valid with 0x55 while busy -> 0x55 is ignored; after done, a fresh load of 0x55 is accepted and emits 1,0,1,0,1,0,1,0 (LSB-first).
- Assert abort after the 3rd bit -> next cycle state IDLE, shreg=0, no done, ser_out=IDLE_LEVEL; the next frame is emitted intact.
- Assert reset asynchronously mid-clock after the 5th bit -> outputs clear immediately, without waiting for a clock edge; after release, load_ready=1 and no residual bits are emitted.
